// File: rtl/gmii_pkg.sv
// Shared GMII TX constants, scheduler state encoding and a one-hot decode helper.
package gmii_pkg;

  localparam logic [7:0] GMII_PREAMBLE = 8'h55;
  localparam logic [7:0] GMII_SFD      = 8'hD5;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    DRAIN,
    IFG
  } tx_state_t;

  // Sized for the largest supported NUM_REQ (8); callers zero-extend the grant.
  function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/gmii_tx_scheduler_if.sv
// Per-source byte-stream handshake bundle feeding the GMII TX scheduler.
interface gmii_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0][7:0] req_tdata;
  logic [NUM_REQ-1:0]      req_tvalid;
  logic [NUM_REQ-1:0]      req_tlast;
  logic [NUM_REQ-1:0]      req_tready;

  modport master (output req_tdata, req_tvalid, req_tlast, input req_tready);
  modport slave  (input req_tdata, req_tvalid, req_tlast, output req_tready);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr, cyclically.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [NUM_REQ-1:0] req_rot;
  logic [NUM_REQ-1:0] gnt_rot;
  logic [NUM_REQ-1:0] req_unused;
  logic [NUM_REQ-1:0] gnt_unused;

  // Rotate so rr_ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    {req_unused, req_rot} = {req, req} >> rr_ptr;
    gnt_rot               = req_rot & (~req_rot + NUM_REQ'(1));
    {grant, gnt_unused}   = {gnt_rot, gnt_rot} << rr_ptr;
  end

endmodule

// File: rtl/gmii_tx_scheduler.sv
// Round-robin sharing of one GMII TX port among NUM_REQ frame sources, with
// preamble/SFD insertion, inter-frame gap and underrun signalling on gmiitxer.
module gmii_tx_scheduler
  import gmii_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int PREAMBLE_BYTES = 7,
  parameter int IFG_BYTES      = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  gmii_tx_scheduler_if.slave   src,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           gmiitxd,
  output logic                 gmiitxen,
  output logic                 gmiitxer,
  output logic [15:0]          frame_cnt,
  output logic [15:0]          underrun_cnt
);

  localparam int PTR_W   = $clog2(NUM_REQ);
  localparam int MAX_CNT = (PREAMBLE_BYTES > IFG_BYTES) ? PREAMBLE_BYTES : IFG_BYTES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  tx_state_t          state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gidx;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [7:0]         sel_data;
  logic               sel_valid;
  logic               sel_last;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (src.req_tvalid),
    .rr_ptr (rr_ptr),
    .grant  (arb_gnt)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_data = sel_data | src.req_tdata[i];
    end
    sel_valid = |(src.req_tvalid & grant);
    sel_last  = |(src.req_tlast & grant);
  end

  // Owner is the only source ever made ready, and only while its bytes are wanted.
  assign src.req_tready = (state == SFD || state == DATA || state == DRAIN) ? grant : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      gidx         <= '0;
      grant        <= '0;
      cnt          <= '0;
      gmiitxd      <= 8'h00;
      gmiitxen     <= 1'b0;
      gmiitxer     <= 1'b0;
      frame_cnt    <= '0;
      underrun_cnt <= '0;
    end else begin
      gmiitxd  <= 8'h00;
      gmiitxen <= 1'b0;
      gmiitxer <= 1'b0;
      case (state)
        IDLE: begin
          if (|src.req_tvalid) begin
            grant    <= arb_gnt;
            gidx     <= PTR_W'(oh_to_idx(8'(arb_gnt)));
            cnt      <= CNT_W'(1);
            gmiitxd  <= GMII_PREAMBLE;
            gmiitxen <= 1'b1;
            state    <= PREAMBLE;
          end
        end
        PREAMBLE: begin
          gmiitxen <= 1'b1;
          if (cnt == CNT_W'(PREAMBLE_BYTES)) begin
            gmiitxd <= GMII_SFD;
            state   <= SFD;
          end else begin
            gmiitxd <= GMII_PREAMBLE;
            cnt     <= cnt + CNT_W'(1);
          end
        end
        SFD, DATA: begin
          gmiitxen <= 1'b1;
          if (sel_valid) begin
            gmiitxd <= sel_data;
            if (sel_last) begin
              frame_cnt <= frame_cnt + 16'd1;
              cnt       <= '0;
              state     <= IFG;
            end else begin
              state <= DATA;
            end
          end else begin
            // Source starved the wire: poison this cycle, then swallow the rest of the frame.
            gmiitxer <= 1'b1;
            if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (sel_valid && sel_last) begin
            cnt   <= '0;
            state <= IFG;
          end
        end
        IFG: begin
          // First IFG cycle still shows the final byte, hence counting 0..IFG_BYTES.
          if (cnt == CNT_W'(IFG_BYTES)) begin
            grant  <= '0;
            rr_ptr <= (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + PTR_W'(1);
            state  <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_scheduler.sv
// Randomized and directed frame traffic against a per-frame output-stream model.
module tb_gmii_tx_scheduler;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] grant;
  logic [7:0]   txd;
  logic         txen, txer;
  logic [15:0]  fcnt, ucnt;

  always #5 clk = ~clk;

  gmii_tx_scheduler_if #(.NUM_REQ(N)) bif ();

  gmii_tx_scheduler #(.NUM_REQ(N), .PREAMBLE_BYTES(7), .IFG_BYTES(12)) dut (
    .clk          (clk),
    .reset        (reset),
    .src          (bif),
    .grant        (grant),
    .gmiitxd      (txd),
    .gmiitxen     (txen),
    .gmiitxer     (txer),
    .frame_cnt    (fcnt),
    .underrun_cnt (ucnt)
  );

  typedef struct packed {logic v; logic last; logic [7:0] d;} beat_t;
  typedef struct {int len; int k; int g;} frm_t;
  typedef struct packed {logic en; logic er; logic [7:0] d; logic [N-1:0] gnt; logic [N-1:0] rdy;} cyc_t;

  beat_t      sq[N][$];
  frm_t       fq[N][$];
  logic [7:0] eb[N][$];
  logic [7:0] pay[$];
  cyc_t       exp_q[$];
  int total = 0, bad = 0;
  int m_rr = 0, m_fr = 0, m_un = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (sq[i].size() == 0) begin
        bif.req_tvalid[i] = 1'b0;
        bif.req_tlast[i]  = 1'b0;
        bif.req_tdata[i]  = 8'h00;
      end else begin
        bif.req_tvalid[i] = sq[i][0].v;
        bif.req_tlast[i]  = sq[i][0].last;
        bif.req_tdata[i]  = sq[i][0].d;
      end
    end
  endtask

  // A source's head beat (byte or stall slot) is consumed whenever it is made ready.
  task automatic tick();
    logic [N-1:0] rdy;
    rdy = bif.req_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rdy[i] && sq[i].size() > 0) void'(sq[i].pop_front());
    end
    drive();
  endtask

  // Frame of pay[] from source s; g>0 inserts g idle slots after k bytes (underrun).
  task automatic add_frame(input int s, input int k, input int g);
    int len;
    len = pay.size();
    for (int j = 0; j < len; j++) begin
      if (g > 0 && j == k) begin
        for (int x = 0; x < g; x++) sq[s].push_back('{1'b0, 1'b0, 8'h00});
      end
      sq[s].push_back('{1'b1, (j == len - 1), pay[j]});
      eb[s].push_back(pay[j]);
    end
    fq[s].push_back('{len, k, g});
  endtask

  task automatic rand_pay(input int len);
    pay.delete();
    for (int j = 0; j < len; j++) pay.push_back(8'($urandom));
  endtask

  // Expected wire activity per frame: 7x55, D5, bytes, 12 idle owned cycles, 1 idle free cycle.
  task automatic build();
    int s, nb, tot;
    frm_t f;
    logic [N-1:0] gb;
    cyc_t e;
    exp_q.delete();
    forever begin
      s = -1;
      for (int o = 0; o < N; o++) begin
        if (s < 0 && fq[(m_rr + o) % N].size() > 0) s = (m_rr + o) % N;
      end
      if (s < 0) break;
      f   = fq[s].pop_front();
      gb  = N'(1) << s;
      nb  = (f.g > 0) ? f.k : f.len;
      tot = 21 + f.len + f.g;
      for (int c = 1; c <= tot; c++) begin
        e = '0;
        if (c <= 7) begin e.en = 1'b1; e.d = 8'h55; end
        else if (c == 8) begin e.en = 1'b1; e.d = 8'hD5; end
        else if (c <= 8 + nb) begin e.en = 1'b1; e.d = eb[s][c - 9]; end
        else if (c == 9 + nb && f.g > 0) begin e.en = 1'b1; e.er = 1'b1; end
        if (c <= 20 + f.len + f.g) e.gnt = gb;
        if (c >= 8 && c <= 7 + f.len + f.g) e.rdy = gb;
        exp_q.push_back(e);
      end
      for (int j = 0; j < f.len; j++) void'(eb[s].pop_front());
      m_rr = (s + 1) % N;
      if (f.g > 0) m_un++;
      else m_fr++;
    end
  endtask

  task automatic run(input string name);
    cyc_t e;
    build();
    drive();
    for (int j = 0; j < exp_q.size(); j++) begin
      tick();
      e = exp_q[j];
      chk($sformatf("%s txen@%0d", name, j), 32'(txen), 32'(e.en));
      chk($sformatf("%s txer@%0d", name, j), 32'(txer), 32'(e.er));
      chk($sformatf("%s txd@%0d", name, j), 32'(txd), 32'(e.d));
      chk($sformatf("%s grant@%0d", name, j), 32'(grant), 32'(e.gnt));
      chk($sformatf("%s tready@%0d", name, j), 32'(bif.req_tready), 32'(e.rdy));
    end
    chk({name, " frame_cnt"}, 32'(fcnt), 32'(m_fr % 65536));
    chk({name, " underrun_cnt"}, 32'(ucnt), 32'(m_un));
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, " txd"}, 32'(txd), 32'h0);
    chk({name, " txen"}, 32'(txen), 32'h0);
    chk({name, " txer"}, 32'(txer), 32'h0);
    chk({name, " grant"}, 32'(grant), 32'h0);
    chk({name, " tready"}, 32'(bif.req_tready), 32'h0);
    chk({name, " frame_cnt"}, 32'(fcnt), 32'h0);
    chk({name, " underrun_cnt"}, 32'(ucnt), 32'h0);
  endtask

  initial begin
    int nsrc, len, k, g;
    reset = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;

    // Two simultaneous requesters from rr_ptr=0: 0 first, then 2.
    rand_pay(6);  add_frame(0, 0, 0);
    rand_pay(9);  add_frame(2, 0, 0);
    run("two_src");

    pay.delete();
    for (int j = 0; j < 64; j++) pay.push_back(8'(j));
    add_frame(0, 0, 0);
    run("frame64");

    rand_pay(20); add_frame(1, 10, 3);
    run("underrun");

    pay.delete(); pay.push_back(8'hA5);
    add_frame(3, 0, 0);
    run("one_byte");

    for (int s = 0; s < N; s++) begin rand_pay($urandom_range(1, 5)); add_frame(s, 0, 0); end
    rand_pay(3); add_frame(0, 0, 0);
    run("all_four");

    // Reset while byte 5 of a frame is on the wire.
    rand_pay(20); add_frame(0, 0, 0);
    drive();
    repeat (13) tick();
    chk("pre_reset txd", 32'(txd), 32'(pay[4]));
    chk("pre_reset txen", 32'(txen), 32'h1);
    reset = 1'b1;
    tick();
    chk_reset_vals("mid_reset");
    reset = 1'b0;
    for (int s = 0; s < N; s++) begin sq[s].delete(); fq[s].delete(); eb[s].delete(); end
    drive();
    m_rr = 0; m_fr = 0; m_un = 0;
    rand_pay(8); add_frame(2, 0, 0);
    run("after_reset");

    for (int r = 0; r < 5; r++) begin
      nsrc = 0;
      for (int s = 0; s < N; s++) begin
        if ($urandom_range(0, 1) == 1 || (s == N - 1 && nsrc == 0)) begin
          nsrc++;
          for (int f = 0; f < int'($urandom_range(1, 2)); f++) begin
            len = $urandom_range(1, 16);
            rand_pay(len);
            k = 0; g = 0;
            if (len >= 2 && $urandom_range(0, 3) == 0) begin
              k = $urandom_range(1, len - 1);
              g = $urandom_range(1, 3);
            end
            add_frame(s, k, g);
          end
        end
      end
      run($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
